hit_judge: RTL and testbench
============================

Name: hit_judge

Overview:
- Player-input end of the LED bounce game; the counterpart of the LED driver.
- Synchronizes and debounces the player push-button and detects presses.
- Reads the one-hot LED position the driver produces and judges each press as a hit (lit LED inside the target mask) or a miss.
- Keeps score and lives, and generates the game_start / game_over levels that the LED driver consumes.

Parameters:
- DEBOUNCE_MS, 20: button must be stable this many i_tick periods before the debounced level changes.
- TARGET_MASK, 8'b1000_0001: LED positions that count as a hit.
- MAX_LIVES, 3: lives loaded at game start; range 1..3.
- SCORE_W, 8: score counter width.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- i_tick  in  1  1 ms single-cycle tick
- i_btn  in  1  raw push-button, active-high, asynchronous to clk
- i_led  in  8  one-hot LED position from the LED driver; 0 = not running
- o_game_start  out  1  level; high in PLAY and OVER
- o_game_over  out  1  level; high in OVER
- o_score  out  SCORE_W  current score
- o_lives  out  2  remaining lives
- o_hit  out  1  one-cycle pulse on a hit judgement
- o_miss  out  1  one-cycle pulse on a miss judgement

Behaviour:
- Reset (async, any time, mid-game included):
  - State IDLE; all outputs 0.
  - Synchronizer and debounced level 0; debounce counter 0.
- Input path:
  - i_btn passes through a 2-FF synchronizer (btn_s).
  - Debounce counter clears whenever btn_s equals the debounced level.
  - Otherwise the counter increments on each i_tick. When it reaches DEBOUNCE_MS-1 on a tick, the debounced level takes btn_s and the counter clears.
  - Counter width is sized for DEBOUNCE_MS.
- Press event: one-cycle pulse on a 0->1 edge of the debounced level. Release produces no event.
- Latency: a clean press held 20 ticks gives its press event 2 clk (sync) + 20 ticks later.
- FSM:
  - IDLE: start=0, over=0. Press -> PLAY; score <= 0, lives <= MAX_LIVES.
  - PLAY: start=1. On press, i_led is sampled in the same clk as the press event.
    - i_led == 0 (driver not yet running): press ignored, no pulse.
    - Exactly one bit set and (i_led & TARGET_MASK) != 0: hit. Score +1, saturating at all-ones (no wrap). o_hit pulses one clk after the press event.
    - Any other nonzero i_led (non-target or non-one-hot): miss. o_miss pulses one clk after the press event.
    - Miss with lives > 1: lives -1, stay in PLAY.
    - Miss with lives == 1: lives <= 0 -> OVER.
  - OVER: start=1, over=1 (the LED driver blanks). Score and lives are held. Press -> IDLE, with score and lives held until the next PLAY entry clears them.
- Press event and i_tick in the same clk: both are processed normally; they are independent.
- o_hit and o_miss are never high together; at most one judgement per press.

Optional Feature:
- HIT_COMBO_EN defined: a 2-bit combo counter, saturating at 3, increments on each hit and clears on a miss or on PLAY entry.
  - A hit made while combo == 3 (before increment) adds 2 to score instead of 1, still saturating.
  - Extra output o_combo [1:0].
- Not defined: no combo logic and no o_combo port; every hit adds 1.

Test Plan:
1. Reset, then i_btn=1 held 25 ticks -> exactly one press event; IDLE->PLAY; start=1, score=0, lives=3.
2. Bounce: in PLAY, i_btn toggles every 5 ticks for 50 ticks, then returns to 0 -> no press event, no o_hit/o_miss, score and lives unchanged.
3. PLAY, i_led=8'h80, clean press -> o_hit for 1 clk, score 0->1. Repeat with i_led=8'h01 -> score 2.
4. PLAY, lives=3, three presses with i_led=8'h08 -> three o_miss pulses; lives 2,1,0; OVER with over=1 and start=1; next press -> IDLE with start=0, score held.
5. Assert rst mid-PLAY with score=5 -> all outputs 0 immediately, IDLE. Also: press with i_led=0 in PLAY -> ignored. SCORE_W=2 with 4 hits -> score stays 3.
6. HIT_COMBO_EN: five consecutive hits -> score 1,2,3,5,7 and o_combo 1,2,3,3,3; then a miss -> o_combo=0.

Source files
------------

// File: rtl/hit_judge_if.sv
// Player-side bundle between the game logic and its environment (tick, button, LED position in; game levels, score, judgements out).
// Optional macro HIT_COMBO_EN adds the o_combo signal.
interface hit_judge_if #(
    parameter int SCORE_W = 8
);
    logic               i_tick;
    logic               i_btn;
    logic [7:0]         i_led;
    logic               o_game_start;
    logic               o_game_over;
    logic [SCORE_W-1:0] o_score;
    logic [1:0]         o_lives;
    logic               o_hit;
    logic               o_miss;
`ifdef HIT_COMBO_EN
    logic [1:0]         o_combo;
`endif

    modport master (
        output i_tick,
        output i_btn,
        output i_led,
        input  o_game_start,
        input  o_game_over,
        input  o_score,
        input  o_lives,
        input  o_hit,
`ifdef HIT_COMBO_EN
        input  o_combo,
`endif
        input  o_miss
    );

    modport slave (
        input  i_tick,
        input  i_btn,
        input  i_led,
        output o_game_start,
        output o_game_over,
        output o_score,
        output o_lives,
        output o_hit,
`ifdef HIT_COMBO_EN
        output o_combo,
`endif
        output o_miss
    );
endinterface

// File: rtl/hit_judge.sv
// Button debounce, press judgement against the LED position, score/lives keeping and game start/over levels.
// Optional macro HIT_COMBO_EN enables a saturating hit-combo counter with a double-score bonus.
module hit_judge #(
    parameter int          DEBOUNCE_MS = 20,
    parameter logic [7:0]  TARGET_MASK = 8'b1000_0001,
    parameter int          MAX_LIVES   = 3,
    parameter int          SCORE_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    hit_judge_if.slave  bus
);
    localparam int                 CNT_W      = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    logic               btn_meta_reg, btn_s_reg;
    logic               deb_level_reg, deb_prev_reg;
    logic [CNT_W-1:0]   deb_cnt_reg;
    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [1:0]         lives_reg, lives_next;
    logic               hit_reg, hit_next;
    logic               miss_reg, miss_next;
    logic               press;
    logic               led_nonzero, led_onehot, led_is_hit;
    logic [1:0]         score_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
`ifdef HIT_COMBO_EN
    logic [1:0]         combo_reg, combo_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_reg <= 1'b0;
            btn_s_reg    <= 1'b0;
        end else begin
            btn_meta_reg <= bus.i_btn;
            btn_s_reg    <= btn_meta_reg;
        end
    end

    // Counter only runs while the synchronized button disagrees with the debounced level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level_reg <= 1'b0;
            deb_prev_reg  <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            deb_prev_reg <= deb_level_reg;
            if (btn_s_reg == deb_level_reg) begin
                deb_cnt_reg <= '0;
            end else if (bus.i_tick) begin
                if (deb_cnt_reg == CNT_LAST) begin
                    deb_level_reg <= btn_s_reg;
                    deb_cnt_reg   <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign press = deb_level_reg & ~deb_prev_reg;

    assign led_nonzero = |bus.i_led;
    assign led_onehot  = led_nonzero && ((bus.i_led & (bus.i_led - 8'd1)) == 8'd0);
    assign led_is_hit  = led_onehot && |(bus.i_led & TARGET_MASK);

    always_comb begin
`ifdef HIT_COMBO_EN
        score_inc = (combo_reg == 2'd3) ? 2'd2 : 2'd1;
`else
        score_inc = 2'd1;
`endif
        score_sum = {1'b0, score_reg} + (SCORE_W + 1)'(score_inc);
        score_sat = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    always_comb begin
        state_next = state_reg;
        score_next = score_reg;
        lives_next = lives_reg;
        hit_next   = 1'b0;
        miss_next  = 1'b0;
`ifdef HIT_COMBO_EN
        combo_next = combo_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (press) begin
                    state_next = PLAY;
                    score_next = '0;
                    lives_next = LIVES_INIT;
`ifdef HIT_COMBO_EN
                    combo_next = 2'd0;
`endif
                end
            end
            PLAY: begin
                // A blank LED means the driver has not started yet; such presses are dropped.
                if (press && led_nonzero) begin
                    if (led_is_hit) begin
                        hit_next   = 1'b1;
                        score_next = score_sat;
`ifdef HIT_COMBO_EN
                        combo_next = (combo_reg == 2'd3) ? 2'd3 : combo_reg + 2'd1;
`endif
                    end else begin
                        miss_next = 1'b1;
`ifdef HIT_COMBO_EN
                        combo_next = 2'd0;
`endif
                        if (lives_reg > 2'd1) begin
                            lives_next = lives_reg - 2'd1;
                        end else begin
                            lives_next = 2'd0;
                            state_next = OVER;
                        end
                    end
                end
            end
            OVER: begin
                if (press) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            score_reg <= '0;
            lives_reg <= 2'd0;
            hit_reg   <= 1'b0;
            miss_reg  <= 1'b0;
`ifdef HIT_COMBO_EN
            combo_reg <= 2'd0;
`endif
        end else begin
            state_reg <= state_next;
            score_reg <= score_next;
            lives_reg <= lives_next;
            hit_reg   <= hit_next;
            miss_reg  <= miss_next;
`ifdef HIT_COMBO_EN
            combo_reg <= combo_next;
`endif
        end
    end

    assign bus.o_game_start = (state_reg != IDLE);
    assign bus.o_game_over  = (state_reg == OVER);
    assign bus.o_score      = score_reg;
    assign bus.o_lives      = lives_reg;
    assign bus.o_hit        = hit_reg;
    assign bus.o_miss       = miss_reg;
`ifdef HIT_COMBO_EN
    assign bus.o_combo      = combo_reg;
`endif
endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: a full-width and a 2-bit-score instance share the same stimulus.
// Combo checks are compiled in when HIT_COMBO_EN is defined.
module tb_hit_judge;
    localparam logic [7:0] TARGET = 8'b1000_0001;
    localparam int         MAXL   = 3;
`ifdef HIT_COMBO_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    typedef struct {
        bit is_hit;
        int score;
        int score2;
        int lives;
        int combo;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_state = 0;
    int m_score = 0;
    int m_score2 = 0;
    int m_lives = 0;
    int m_combo = 0;

    hit_judge_if #(.SCORE_W(8)) bus ();
    hit_judge_if #(.SCORE_W(2)) bus2 ();

    assign bus2.i_tick = bus.i_tick;
    assign bus2.i_btn  = bus.i_btn;
    assign bus2.i_led  = bus.i_led;

    hit_judge #(.SCORE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    hit_judge #(.SCORE_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle tick every 5 clocks stands in for the 1 ms strobe.
    initial begin
        bus.i_tick = 1'b0;
        forever begin
            repeat (4) @(posedge clk);
            #1 bus.i_tick = 1'b1;
            @(posedge clk);
            #1 bus.i_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_hit && bus.o_miss) check("hit_and_miss", 32'd1, {31'd0, bus.o_miss & ~bus.o_hit});
            if (bus.o_hit || bus.o_miss) begin
                check("pulse_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("judge: hit=%0d miss=%0d score=%0d lives=%0d", bus.o_hit, bus.o_miss, bus.o_score, bus.o_lives);
                    check("pulse_hit", 32'(bus.o_hit), 32'(e.is_hit));
                    check("pulse_score", 32'(bus.o_score), 32'(e.score));
                    check("pulse_lives", 32'(bus.o_lives), 32'(e.lives));
                    check("pulse_score2", 32'(bus2.o_score), 32'(e.score2));
                    check("pulse_hit2", 32'(bus2.o_hit), 32'(e.is_hit));
`ifdef HIT_COMBO_EN
                    check("pulse_combo", 32'(bus.o_combo), 32'(e.combo));
`endif
                end
            end
        end
    end

    task automatic check_levels(input string tag);
        check({tag, "_start"}, 32'(bus.o_game_start), 32'(m_state != 0));
        check({tag, "_over"}, 32'(bus.o_game_over), 32'(m_state == 2));
        check({tag, "_score"}, 32'(bus.o_score), 32'(m_score));
        check({tag, "_score2"}, 32'(bus2.o_score), 32'(m_score2));
        check({tag, "_lives"}, 32'(bus.o_lives), 32'(m_lives));
        check({tag, "_pulses"}, 32'({bus.o_hit, bus.o_miss}), 32'd0);
`ifdef HIT_COMBO_EN
        check({tag, "_combo"}, 32'(bus.o_combo), 32'(m_combo));
`endif
    endtask

    task automatic do_press(input logic [7:0] led, input string tag);
        exp_t e;
        int   inc;
        bus.i_led = led;
        case (m_state)
            0: begin
                m_state = 1; m_score = 0; m_score2 = 0; m_lives = MAXL; m_combo = 0;
            end
            1: begin
                if (led != 8'd0) begin
                    e.is_hit = $onehot(led) && ((led & TARGET) != 8'd0);
                    if (e.is_hit) begin
                        inc = (COMBO && m_combo == 3) ? 2 : 1;
                        m_score  = (m_score + inc > 255) ? 255 : m_score + inc;
                        m_score2 = (m_score2 + inc > 3) ? 3 : m_score2 + inc;
                        m_combo  = (m_combo == 3) ? 3 : m_combo + 1;
                    end else begin
                        m_combo = 0;
                        m_lives = m_lives - 1;
                        if (m_lives == 0) m_state = 2;
                    end
                    e.score = m_score; e.score2 = m_score2; e.lives = m_lives; e.combo = m_combo;
                    sb.push_back(e);
                end
            end
            default: m_state = 0;
        endcase
        bus.i_btn = 1'b1;
        repeat (25) @(posedge bus.i_tick);
        bus.i_btn = 1'b0;
        repeat (25) @(posedge bus.i_tick);
        @(posedge clk);
        #2;
        $display("press %s: led=%h start=%0d over=%0d score=%0d lives=%0d", tag, led, bus.o_game_start, bus.o_game_over, bus.o_score, bus.o_lives);
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
        check_levels(tag);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_btn = 1'b0;
        bus.i_led = 8'd0;
        repeat (3) @(posedge clk);
        #2;
        check_levels("reset");
        rst = 1'b0;

        do_press(8'h00, "start");

        for (int i = 0; i < 10; i++) begin
            bus.i_btn = (i % 2 == 0);
            repeat (5) @(posedge bus.i_tick);
        end
        bus.i_btn = 1'b0;
        repeat (25) @(posedge bus.i_tick);
        #2;
        $display("bounce: score=%0d lives=%0d", bus.o_score, bus.o_lives);
        check_levels("bounce");

        do_press(8'h00, "blank_led");
        do_press(8'h80, "hit80");
        do_press(8'h01, "hit01");
        do_press(8'h80, "hit80b");
        do_press(8'h01, "hit01b");
        do_press(8'h81, "miss_multi");
        do_press(8'h08, "miss08");
        do_press(8'h08, "miss_last");
        do_press(8'h80, "over_to_idle");
        do_press(8'h00, "restart");
        for (int i = 0; i < 5; i++) do_press((i % 2 == 0) ? 8'h80 : 8'h01, "combo_hit");
        do_press(8'h10, "combo_miss");

        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        m_state = 0; m_score = 0; m_score2 = 0; m_lives = 0; m_combo = 0;
        $display("async reset: start=%0d score=%0d lives=%0d", bus.o_game_start, bus.o_score, bus.o_lives);
        check_levels("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        do_press(8'h00, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
